// File: rtl/board_store.sv
// board_store: one player's COLS x ROWS playfield plus line clearing, BCD score and top-out.
// The display reads cells combinationally through raddr/rdata; this block is the only writer.
// Optional feature macro GARBAGE_EN: when defined, garbage_req pushes the board up one row
// and inserts a garbage row at the bottom; when undefined, garbage_req/garbage_hole are ignored.
module board_store #(
  parameter int COLS     = 10,
  parameter int ROWS     = 20,
  parameter int TOP_ROWS = 3
) (
  input  logic       pclk,
  input  logic       rstn,
  input  logic [7:0] raddr,
  output logic [2:0] rdata,
  input  logic       lock_start,
  input  logic [4:0] x1,
  input  logic [4:0] y1,
  input  logic [4:0] x2,
  input  logic [4:0] y2,
  input  logic [4:0] x3,
  input  logic [4:0] y3,
  input  logic [4:0] x4,
  input  logic [4:0] y4,
  input  logic [2:0] ptype,
  input  logic       clr_start,
  input  logic       garbage_req,
  input  logic [3:0] garbage_hole,
  output logic       busy,
  output logic       done,
  output logic [2:0] lines,
  output logic [7:0] score,
  output logic       fail
);
  localparam int CELLS = COLS * ROWS;

  typedef enum logic [2:0] {IDLE, LOCK, SCAN, SHIFT, WIPE, GARB, DONE} state_t;
  typedef enum logic [1:0] {OP_LOCK, OP_CLR, OP_GARB} op_t;

  logic [CELLS-1:0][2:0] mem;
  state_t                state;
  op_t                   op;
  logic [3:0][4:0]       px, py;   // captured piece cells
  logic [2:0]            pt;
  logic [1:0]            k;        // LOCK cell index
  logic [4:0]            r;        // SCAN row / WIPE row
  logic [4:0]            j;        // SHIFT / GARB row
  logic [2:0]            cnt;      // rows cleared by this lock
  logic                  full_r;
  logic                  top_hit;

`ifdef GARBAGE_EN
  logic [3:0]            hole;
`else
  logic                  unused_garb;
  assign unused_garb = ^{garbage_req, garbage_hole};
`endif

  function automatic logic [7:0] idx(input logic [4:0] y, input logic [4:0] x);
    return 8'(y) * 8'(COLS) + 8'(x);
  endfunction

  // Two-digit BCD add of a 0..4 increment, saturating at 99.
  function automatic logic [7:0] bcd_add(input logic [7:0] s, input logic [2:0] n);
    logic [4:0] u;
    logic [3:0] t;
    u = {1'b0, s[3:0]} + {2'b0, n};
    t = s[7:4];
    if (u > 5'd9) begin
      u = u - 5'd10;
      t = t + 4'd1;
    end
    if (t > 4'd9) return 8'h99;
    return {t, u[3:0]};
  endfunction

  // Display read port; out-of-range addresses read as empty.
  always_comb begin
    rdata = 3'd0;
    if (raddr < 8'(CELLS)) rdata = mem[raddr];
  end

  // Row r has no empty cell.
  always_comb begin
    full_r = 1'b1;
    for (int c = 0; c < COLS; c++)
      if (mem[idx(r, 5'(c))] == 3'd0) full_r = 1'b0;
  end

  // Any occupied cell in the spawn zone means top-out.
  always_comb top_hit = |mem[TOP_ROWS*COLS-1:0];

  // Control FSM and sole writer of the playfield.
  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) begin
      mem   <= '0;
      state <= IDLE;
      op    <= OP_LOCK;
      busy  <= 1'b0;
      done  <= 1'b0;
      lines <= 3'd0;
      score <= 8'h00;
      fail  <= 1'b0;
      px    <= '0;
      py    <= '0;
      pt    <= 3'd0;
      k     <= 2'd0;
      r     <= 5'd0;
      j     <= 5'd0;
      cnt   <= 3'd0;
`ifdef GARBAGE_EN
      hole  <= 4'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (clr_start) begin
            op    <= OP_CLR;
            r     <= 5'd0;
            busy  <= 1'b1;
            state <= WIPE;
          end else if (lock_start) begin
            op    <= OP_LOCK;
            px    <= {x4, x3, x2, x1};
            py    <= {y4, y3, y2, y1};
            pt    <= ptype;
            k     <= 2'd0;
            busy  <= 1'b1;
            state <= LOCK;
          end
`ifdef GARBAGE_EN
          else if (garbage_req) begin
            op    <= OP_GARB;
            hole  <= garbage_hole;
            j     <= 5'd0;
            busy  <= 1'b1;
            state <= GARB;
          end
`endif
        end
        LOCK: begin
          // off-board cells still cost their cycle
          if (px[k] < 5'(COLS) && py[k] < 5'(ROWS)) mem[idx(py[k], px[k])] <= pt;
          k <= k + 2'd1;
          if (k == 2'd3) begin
            r     <= 5'(ROWS-1);
            cnt   <= 3'd0;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (full_r) begin
            j     <= r;
            state <= SHIFT;
          end else if (r == 5'd0) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            r <= r - 5'd1;
          end
        end
        SHIFT: begin
          // rows above drop by one; row r is rescanned afterwards
          if (j == 5'd0) begin
            for (int c = 0; c < COLS; c++) mem[c] <= 3'd0;
            cnt   <= cnt + 3'd1;
            state <= SCAN;
          end else begin
            for (int c = 0; c < COLS; c++)
              mem[idx(j, 5'(c))] <= mem[idx(j - 5'd1, 5'(c))];
            j <= j - 5'd1;
          end
        end
        WIPE: begin
          for (int c = 0; c < COLS; c++) mem[idx(r, 5'(c))] <= 3'd0;
          if (r == 5'(ROWS-1)) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            r <= r + 5'd1;
          end
        end
`ifdef GARBAGE_EN
        GARB: begin
          // board moves up; bottom row becomes garbage with one hole
          if (j == 5'(ROWS-1)) begin
            for (int c = 0; c < COLS; c++)
              mem[idx(5'(ROWS-1), 5'(c))] <= (4'(c) == hole) ? 3'd0 : 3'b111;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            for (int c = 0; c < COLS; c++)
              mem[idx(j, 5'(c))] <= mem[idx(j + 5'd1, 5'(c))];
            j <= j + 5'd1;
          end
        end
`endif
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
          case (op)
            OP_LOCK: begin
              lines <= cnt;
              score <= bcd_add(score, cnt);
              if (top_hit) fail <= 1'b1;
            end
            OP_CLR: begin
              lines <= 3'd0;
              score <= 8'h00;
              fail  <= 1'b0;
            end
            default: if (top_hit) fail <= 1'b1;
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_board_store.sv
// Self-checking bench for board_store: a reference board model predicts each operation's
// latency, lines, score and fail into a queue that is popped when done is seen.
module tb_board_store;
  localparam int COLS = 10, ROWS = 20, CELLS = 200;

  logic       pclk = 1'b0, rstn = 1'b0;
  logic [7:0] raddr = 8'd0;
  logic [2:0] rdata;
  logic       lock_start = 1'b0, clr_start = 1'b0, garbage_req = 1'b0;
  logic [4:0] x1 = 0, y1 = 0, x2 = 0, y2 = 0, x3 = 0, y3 = 0, x4 = 0, y4 = 0;
  logic [2:0] ptype = 3'd0;
  logic [3:0] garbage_hole = 4'd0;
  logic       busy, done, fail;
  logic [2:0] lines;
  logic [7:0] score;

  always #5 pclk = ~pclk;

  board_store dut (
    .pclk(pclk), .rstn(rstn), .raddr(raddr), .rdata(rdata),
    .lock_start(lock_start),
    .x1(x1), .y1(y1), .x2(x2), .y2(y2), .x3(x3), .y3(y3), .x4(x4), .y4(y4),
    .ptype(ptype), .clr_start(clr_start),
    .garbage_req(garbage_req), .garbage_hole(garbage_hole),
    .busy(busy), .done(done), .lines(lines), .score(score), .fail(fail)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // reference model
  logic [2:0] mb [CELLS];
  int cx [4], cy [4], ct, chole;
  int m_score = 0, m_fail = 0;
  typedef struct { int lat; int lines; int score; int fail; } exp_t;
  exp_t sb [$];

  function automatic int tobcd(input int d);
    return ((d / 10) << 4) | (d % 10);
  endfunction

  function automatic bit m_full(input int y);
    for (int c = 0; c < COLS; c++) if (mb[y*COLS+c] == 3'd0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int m_top();
    for (int i = 0; i < 3*COLS; i++) if (mb[i] != 3'd0) return 1;
    return 0;
  endfunction

  task automatic model_lock();
    int lat, nl, r;
    for (int q = 0; q < 4; q++)
      if (cx[q] < COLS && cy[q] < ROWS) mb[cy[q]*COLS+cx[q]] = 3'(ct);
    lat = 25; nl = 0; r = ROWS - 1;
    while (r >= 0) begin
      if (m_full(r)) begin
        for (int y = r; y > 0; y--)
          for (int c = 0; c < COLS; c++) mb[y*COLS+c] = mb[(y-1)*COLS+c];
        for (int c = 0; c < COLS; c++) mb[c] = 3'd0;
        nl++;
        lat += r + 2;
      end else r--;
    end
    m_score = (m_score + nl > 99) ? 99 : m_score + nl;
    if (m_top() != 0) m_fail = 1;
    sb.push_back('{lat, nl, tobcd(m_score), m_fail});
  endtask

  task automatic model_clr();
    for (int i = 0; i < CELLS; i++) mb[i] = 3'd0;
    m_score = 0; m_fail = 0;
    sb.push_back('{21, 0, 0, 0});
  endtask

  int last_lines = 0;
  task automatic model_garb();
    for (int y = 0; y < ROWS-1; y++)
      for (int c = 0; c < COLS; c++) mb[y*COLS+c] = mb[(y+1)*COLS+c];
    for (int c = 0; c < COLS; c++) mb[(ROWS-1)*COLS+c] = (c == chole) ? 3'd0 : 3'd7;
    if (m_top() != 0) m_fail = 1;
    sb.push_back('{21, last_lines, tobcd(m_score), m_fail});
  endtask

  task automatic set_piece(input int a, input int b, input int c, input int d,
                           input int e, input int f, input int g, input int h, input int t);
    cx[0] = a; cy[0] = b; cx[1] = c; cy[1] = d;
    cx[2] = e; cy[2] = f; cx[3] = g; cy[3] = h; ct = t;
  endtask

  // kind: 0 lock, 1 clear, 2 garbage, 3 lock+clear on one edge
  task automatic run_op(input int kind, input bit inject);
    exp_t e;
    int n;
    case (kind)
      0: model_lock();
      2: model_garb();
      default: model_clr();
    endcase
    if (kind == 0) last_lines = sb[$].lines;
    if (kind != 0 && kind != 2) last_lines = 0;
    @(negedge pclk);
    x1 = 5'(cx[0]); y1 = 5'(cy[0]); x2 = 5'(cx[1]); y2 = 5'(cy[1]);
    x3 = 5'(cx[2]); y3 = 5'(cy[2]); x4 = 5'(cx[3]); y4 = 5'(cy[3]);
    ptype = 3'(ct);
    garbage_hole = 4'(chole);
    lock_start  = (kind == 0 || kind == 3);
    clr_start   = (kind == 1 || kind == 3);
    garbage_req = (kind == 2);
    @(negedge pclk);
    lock_start = 1'b0; clr_start = 1'b0; garbage_req = 1'b0;
    chk("busy_after_accept", busy, 1);
    n = 1;
    while (!done && n < 2000) begin
      if (inject && n == 2) begin
        lock_start = 1'b1;
        x1 = 0; y1 = 0; x2 = 1; y2 = 0; x3 = 0; y3 = 1; x4 = 1; y4 = 1; ptype = 3'd6;
      end else lock_start = 1'b0;
      @(negedge pclk);
      n++;
    end
    lock_start = 1'b0;
    e = sb.pop_front();
    chk("done_latency", n, e.lat);
    @(negedge pclk);
    chk("done_pulse_end", done, 0);
    chk("busy_end", busy, 0);
    chk("lines", lines, e.lines);
    chk("score", score, e.score);
    chk("fail", fail, e.fail);
  endtask

  task automatic rd(input int a, output logic [2:0] v);
    raddr = 8'(a);
    #1;
    v = rdata;
  endtask

  task automatic chk_board();
    logic [2:0] v;
    for (int a = 0; a < CELLS; a++) begin
      rd(a, v);
      chk($sformatf("cell%0d", a), v, mb[a]);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] v;
    for (int i = 0; i < CELLS; i++) mb[i] = 3'd0;
    chole = 0;
    repeat (3) @(negedge pclk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_lines", lines, 0);
    chk("rst_score", score, 8'h00);
    chk("rst_fail", fail, 0);
    rstn = 1'b1;
    @(negedge pclk);
    chk_board();
    rd(250, v);
    chk("raddr_oob", v, 0);

    // O piece near the floor
    set_piece(4, 18, 5, 18, 4, 19, 5, 19, 4);
    run_op(0, 0);
    rd(184, v); chk("o_184", v, 4);
    rd(185, v); chk("o_185", v, 4);
    rd(194, v); chk("o_194", v, 4);
    rd(195, v); chk("o_195", v, 4);
    chk_board();

    // complete row 19 except column 9, one cell off-board, then an I piece clears it
    set_piece(0, 19, 1, 19, 2, 19, 3, 19, 2);
    run_op(0, 0);
    set_piece(6, 19, 7, 19, 8, 19, 31, 19, 3);
    run_op(0, 0);
    set_piece(9, 16, 9, 17, 9, 18, 9, 19, 1);
    run_op(0, 0);
    chk("single_clear_lines", lines, 1);
    chk("single_clear_score", score, 8'h01);
    rd(199, v); chk("r19c9", v, 1);
    rd(189, v); chk("r18c9", v, 1);
    rd(179, v); chk("r17c9", v, 1);
    rd(169, v); chk("r16c9", v, 0);
    rd(194, v); chk("r19c4_dropped", v, 4);
    chk_board();

    run_op(1, 0);
    chk_board();

    // 24 four-line clears (96), one two-line clear (98), one more four-line clear (sat 99)
    for (int t = 0; t < 24; t++)
      for (int c = 0; c < COLS; c++) begin
        set_piece(c, 16, c, 17, c, 18, c, 19, 1 + (c % 7));
        run_op(0, 0);
      end
    for (int c = 0; c < COLS; c++) begin
      set_piece(c, 18, c, 19, c, 20, c, 21, 2);
      run_op(0, 0);
    end
    chk("score_98", score, 8'h98);
    for (int c = 0; c < COLS; c++) begin
      set_piece(c, 16, c, 17, c, 18, c, 19, 5);
      run_op(0, 0);
    end
    chk("score_sat", score, 8'h99);
    chk("tetris_lines", lines, 4);
    chk_board();

    // top-out, with a lock request pulsed while busy
    set_piece(0, 1, 1, 1, 2, 1, 3, 1, 5);
    run_op(0, 1);
    chk("topout_fail", fail, 1);
    chk_board();
    // locking still accepted with fail set
    set_piece(0, 19, 1, 19, 2, 19, 3, 19, 6);
    run_op(0, 0);
    chk_board();
    run_op(1, 0);
    chk("clr_score", score, 8'h00);
    chk("clr_fail", fail, 0);
    chk_board();

    // clear wins over lock on the same edge
    set_piece(4, 18, 5, 18, 4, 19, 5, 19, 4);
    run_op(0, 0);
    set_piece(0, 19, 1, 19, 2, 19, 3, 19, 3);
    run_op(3, 0);
    chk_board();

`ifdef GARBAGE_EN
    set_piece(0, 19, 31, 0, 31, 0, 31, 0, 7);
    run_op(0, 0);
    chole = 3;
    run_op(2, 0);
    rd(190, v); chk("garb_r19c0", v, 7);
    rd(193, v); chk("garb_hole", v, 0);
    rd(199, v); chk("garb_r19c9", v, 7);
    rd(180, v); chk("garb_lifted", v, 7);
    chk_board();
    chole = 12;
    run_op(2, 0);
    chk_board();
`else
    @(negedge pclk);
    garbage_req = 1'b1;
    garbage_hole = 4'd3;
    repeat (3) begin
      @(negedge pclk);
      chk("garb_ignored_busy", busy, 0);
    end
    garbage_req = 1'b0;
    chk_board();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
